// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file dump engine: FSM state encoding
// and the default data/address widths.
package regfile_pkg;

   localparam int unsigned DW_DEF = 8;
   localparam int unsigned AW_DEF = 3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      READ = 2'd1,
      SEND = 2'd2,
      DONE = 2'd3
   } state_t;

endpackage

// File: rtl/regfile_dump_if.sv
// Streamed-beat bus between the dump engine (master) and its consumer (slave).
// Optional macro REGFILE_DUMP_PARITY_EN adds the dout_par signal.
interface regfile_dump_if #(
   parameter int unsigned DW = regfile_pkg::DW_DEF,
   parameter int unsigned AW = regfile_pkg::AW_DEF
);

   logic [DW-1:0] dout;
   logic [AW-1:0] dout_addr;
   logic          dout_valid;
   logic          dout_ready;
`ifdef REGFILE_DUMP_PARITY_EN
   logic          dout_par;

   modport master (output dout, output dout_addr, output dout_valid, output dout_par,
                   input  dout_ready);
   modport slave  (input  dout, input  dout_addr, input  dout_valid, input  dout_par,
                   output dout_ready);
`else
   modport master (output dout, output dout_addr, output dout_valid,
                   input  dout_ready);
   modport slave  (input  dout, input  dout_addr, input  dout_valid,
                   output dout_ready);
`endif

endinterface

// File: rtl/regfile_dump.sv
// Walks register addresses first..last (wrapping modulo 2^AW), reads each one
// through the combinational read port and streams it out as a valid/ready beat.
// Optional macro REGFILE_DUMP_PARITY_EN adds a registered even-XOR parity bit.
module regfile_dump
   import regfile_pkg::*;
#(
   parameter int unsigned DW = DW_DEF,
   parameter int unsigned AW = AW_DEF
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic [AW-1:0] first,
   input  logic [AW-1:0] last,
   output logic [AW-1:0] ra,
   input  logic [DW-1:0] rd,
   output logic          busy,
   output logic          done,
   regfile_dump_if.master dump
);

   state_t        state_q, state_d;
   logic [AW-1:0] cur_q,   cur_d;
   logic [AW-1:0] end_q,   end_d;
   logic [AW-1:0] addr_q,  addr_d;
   logic [DW-1:0] dout_q,  dout_d;

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next-state: one READ cycle per beat, SEND until the consumer accepts
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (start) state_d = READ;
         READ:    state_d = SEND;
         SEND:    if (dump.dout_ready) state_d = (cur_q == end_q) ? DONE : READ;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Outputs decoded from the current state
   always_comb begin
      busy            = (state_q != IDLE);
      done            = (state_q == DONE);
      dump.dout_valid = (state_q == SEND);
   end

   // Datapath next values: range latch, address walk, beat capture
   always_comb begin
      cur_d  = cur_q;
      end_d  = end_q;
      addr_d = addr_q;
      dout_d = dout_q;
      case (state_q)
         IDLE: if (start) begin
            cur_d = first;
            end_d = last;
         end
         READ: begin
            dout_d = rd;
            addr_d = cur_q;
         end
         SEND: if (dump.dout_ready && (cur_q != end_q)) cur_d = cur_q + AW'(1);
         default: ;
      endcase
   end

   // Datapath registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cur_q  <= '0;
         end_q  <= '0;
         addr_q <= '0;
         dout_q <= '0;
      end else begin
         cur_q  <= cur_d;
         end_q  <= end_d;
         addr_q <= addr_d;
         dout_q <= dout_d;
      end
   end

   assign ra             = cur_q;
   assign dump.dout      = dout_q;
   assign dump.dout_addr = addr_q;

`ifdef REGFILE_DUMP_PARITY_EN
   logic par_q;

   // Parity captured alongside dout so both change on the same edge
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) par_q <= 1'b0;
      else        par_q <= ^dout_d;
   end

   assign dump.dout_par = par_q;
`endif

endmodule

// File: doc/regfile_dump.md
REGFILE_DUMP -- requirements
Module: regfile_dump

Interface
REQ-001 SHALL have parameter DW, default 8, meaning register data width.
REQ-002 SHALL have parameter AW, default 3, meaning register address width.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  request to begin a dump, sampled in IDLE only.
REQ-006 SHALL have port first  input  AW  first register address, sampled with start.
REQ-007 SHALL have port last  input  AW  last register address, sampled with start.
REQ-008 SHALL have port ra  output  AW  read address to the register-file read port.
REQ-009 SHALL have port rd  input  DW  combinational read data returned for ra.
REQ-010 SHALL have port dout  output  DW  streamed register value.
REQ-011 SHALL have port dout_addr  output  AW  address that dout came from.
REQ-012 SHALL have port dout_valid  output  1  dout/dout_addr hold a valid beat.
REQ-013 SHALL have port dout_ready  input  1  consumer accepts the beat.
REQ-014 SHALL have port busy  output  1  high in every state except IDLE.
REQ-015 SHALL have port done  output  1  one-cycle pulse after the final beat is accepted.

Function
REQ-016 SHALL implement states IDLE, READ, SEND, DONE.
REQ-017 IDLE: start=1 SHALL latch cur<=first, end<=last and go to READ next cycle; start=0 stays in IDLE.
REQ-018 READ (exactly one cycle): ra=cur; dout<=rd, dout_addr<=cur registered at cycle end; next state is SEND.
REQ-019 SEND: dout_valid=1; dout and dout_addr SHALL be held stable while dout_ready=0.
REQ-020 In SEND with dout_ready=1 and cur!=end: cur<=cur+1 modulo 2^AW (7 wraps to 0), next state is READ.
REQ-021 In SEND with dout_ready=1 and cur==end: next state is DONE.
REQ-022 DONE: done=1 for exactly one cycle, then IDLE; start is ignored in DONE.
REQ-023 If first>last, the walk SHALL wrap through 2^AW-1 and 0; if first==last, exactly one beat.
REQ-024 Beat count SHALL be ((last-first) mod 2^AW)+1; a full dump (first=last+1 mod 8) yields 8 beats.
REQ-025 Minimum latency: start to first dout_valid = 2 cycles; throughput one beat per 2 cycles with dout_ready held high.
REQ-026 start while busy=1 SHALL be ignored; first/last changes during a dump SHALL have no effect.
REQ-027 ra SHALL equal cur in all states; it is don't-care outside READ but SHALL NOT be X.
REQ-028 The block SHALL NOT write the register file; the value at address 7 is whatever the read port returns.

Reset
REQ-029 reset=0 SHALL immediately force IDLE, cur=0, end=0, ra=0, dout=0, dout_addr=0, dout_valid=0, busy=0, done=0.
REQ-030 reset asserted mid-dump SHALL abort with no done pulse; after release, the block waits for a new start.

Configuration
REQ-031 With REGFILE_DUMP_PARITY_EN defined, there SHALL be an output dout_par (1 bit) equal to the XOR of dout bits, registered with dout and reset to 0.
REQ-032 Without REGFILE_DUMP_PARITY_EN, the dout_par port and its logic SHALL be absent; all other behaviour is identical.

Structure
REQ-033 A shared package regfile_pkg SHALL hold the state enum (IDLE, READ, SEND, DONE) and the DW/AW default constants.
REQ-034 There SHALL be no sub-module; the address counter and FSM are inline.

Verification
REQ-035 regs[0..6]=8'h10..8'h16, r7=8'hA5; start, first=0, last=7, ready=1 -> 8 beats 10,11,...,16,A5 with addr 0..7, then one done pulse.
REQ-036 first=6, last=1 -> beats from addresses 6,7,0,1 only, then done.
REQ-037 first=last=3, ready low for 5 cycles -> dout=regs[3] held stable with valid high for 5 cycles, one beat, then done.
REQ-038 start pulsed again during a dump, first=2 -> ignored; beat count and addresses unchanged.
REQ-039 reset=0 in SEND of the 3rd beat -> all outputs 0 immediately, no done pulse; a new start after release runs normally.
REQ-040 With REGFILE_DUMP_PARITY_EN, dout=8'h07 -> dout_par=1; dout=8'h03 -> dout_par=0.
